axi4_lite_uart_arbiter: RTL and testbench

Two-requester scheduler that shares one AXI4-Lite master port in front of the 32-bit UART slave. It accepts single-word read/write commands from two independent requesters, such as a CPU-side config path and a DMA/stream path. It arbitrates between them round-robin and runs exactly one AXI4-Lite transaction at a time on the slave. It returns a one-cycle response pulse to the winning requester.

---
 rtl/axi4_lite_uart_pkg.sv | 21 ++
 rtl/axi4_lite_rr_arbiter_2.sv | 33 +++
 rtl/axi4_lite_uart_arbiter.sv | 172 +++++++++++++++++
 tb/tb_axi4_lite_uart_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_uart_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite UART arbiter.
package axi4_lite_uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdData,
    StDone
  } state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  localparam int unsigned RegBaud   = 0;
  localparam int unsigned RegCtrl   = 1;
  localparam int unsigned RegTxData = 2;
  localparam int unsigned RegRxData = 3;

endpackage

// File: rtl/axi4_lite_rr_arbiter_2.sv
// Two-way grant logic with last-grant pointer.
// AXI_UART_ARB_FIXED_PRIO_EN selects fixed priority (req 0 wins) and drops the pointer.
module axi4_lite_rr_arbiter_2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  assign gnt_valid_o = |req_i;

`ifdef AXI_UART_ARB_FIXED_PRIO_EN
  logic unused_sig;
  assign unused_sig = ^{clk_i, rst_i, update_i};
  assign gnt_idx_o  = ~req_i[0];
`else
  logic last_grant_q;

  // Resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q <= 1'b1;
    end else if (update_i) begin
      last_grant_q <= gnt_idx_o;
    end
  end

  assign gnt_idx_o = (&req_i) ? ~last_grant_q : req_i[1];
`endif

endmodule

// File: rtl/axi4_lite_uart_arbiter.sv
// Shares one AXI4-Lite master port between two single-word requesters.
// Arbitration mode follows AXI_UART_ARB_FIXED_PRIO_EN (see axi4_lite_rr_arbiter_2).
module axi4_lite_uart_arbiter
  import axi4_lite_uart_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter logic [2:0]  AXPROT = 3'b000
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [31:0]       req0_wdata,
  input  logic [3:0]        req0_wstrb,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [31:0]       req1_wdata,
  input  logic [3:0]        req1_wstrb,
  output logic              resp0_valid,
  output logic [31:0]       resp0_rdata,
  output logic              resp0_err,
  output logic              resp1_valid,
  output logic [31:0]       resp1_rdata,
  output logic              resp1_err,
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awprot,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready
);

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic gnt_valid, gnt_idx, accept;
  logic sel_write;

  // Gated by reset so readies read 0 while reset is held.
  assign accept = (state_q == StIdle) && gnt_valid && !areset;

  axi4_lite_rr_arbiter_2 u_arb (
    .clk_i       (aclk),
    .rst_i       (areset),
    .req_i       ({req1_valid, req0_valid}),
    .update_i    (accept),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  assign sel_write = gnt_idx ? req1_write : req0_write;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          gnt_d     = gnt_idx;
          addr_d    = gnt_idx ? req1_addr  : req0_addr;
          wdata_d   = gnt_idx ? req1_wdata : req0_wdata;
          wstrb_d   = gnt_idx ? req1_wstrb : req0_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = sel_write ? StWrReq : StRdReq;
        end
      end
      StWrReq: begin
        aw_done_d = aw_done_q | (awvalid & awready);
        w_done_d  = w_done_q | (wvalid & wready);
        if (aw_done_d && w_done_d) state_d = StWrResp;
      end
      StWrResp: begin
        if (bvalid) begin
          rdata_d = '0;
          err_d   = bresp[1];
          state_d = StDone;
        end
      end
      StRdReq: begin
        if (arready) state_d = StRdData;
      end
      StRdData: begin
        if (rvalid) begin
          rdata_d = rdata;
          err_d   = rresp[1];
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= StIdle;
      gnt_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign req0_ready = accept && !gnt_idx;
  assign req1_ready = accept && gnt_idx;

  assign resp0_valid = (state_q == StDone) && !gnt_q;
  assign resp1_valid = (state_q == StDone) && gnt_q;
  assign resp0_rdata = resp0_valid ? rdata_q : '0;
  assign resp1_rdata = resp1_valid ? rdata_q : '0;
  assign resp0_err   = resp0_valid & err_q;
  assign resp1_err   = resp1_valid & err_q;

  assign awaddr  = addr_q;
  assign araddr  = addr_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign awprot  = AXPROT;
  assign arprot  = AXPROT;
  assign awvalid = (state_q == StWrReq) && !aw_done_q;
  assign wvalid  = (state_q == StWrReq) && !w_done_q;
  assign bready  = (state_q == StWrResp);
  assign arvalid = (state_q == StRdReq);
  assign rready  = (state_q == StRdData);

endmodule

// File: tb/tb_axi4_lite_uart_arbiter.sv
// Scoreboard bench: expected responses are queued at issue, a negedge monitor pops and compares.
module tb_axi4_lite_uart_arbiter;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        req0_valid = 0, req0_write = 0, req1_valid = 0, req1_write = 0;
  logic [31:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
  logic [3:0]  req0_wstrb = 0, req1_wstrb = 0;
  logic        req0_ready, req1_ready;
  logic        resp0_valid, resp0_err, resp1_valid, resp1_err;
  logic [31:0] resp0_rdata, resp1_rdata;
  logic [31:0] awaddr, araddr, wdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int          aw_delay = 0, aw_wait = 0;
  logic        b_hold = 1'b0;
  logic [1:0]  b_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = 0;

  typedef struct {int idx; logic [31:0] rdata; logic err;} exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  // Slave model: awready after aw_delay waiting cycles, everything else immediate.
  assign awready = awvalid && (aw_wait >= aw_delay);
  assign wready  = wvalid;
  assign bvalid  = bready && !b_hold;
  assign bresp   = b_resp_cfg;
  assign arready = arvalid;
  assign rvalid  = rready;
  assign rdata   = r_data_cfg;
  assign rresp   = 2'b00;

  always @(posedge aclk) begin
    if (awvalid && !awready) aw_wait <= aw_wait + 1;
    else aw_wait <= 0;
  end

  axi4_lite_uart_arbiter dut (
    .aclk(aclk), .areset(areset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int idx, input logic [31:0] d, input logic e);
    exp_t x;
    x.idx = idx; x.rdata = d; x.err = e;
    exp_q.push_back(x);
  endtask

  // Monitor: every response pulse must match the head of the expectation queue.
  always @(negedge aclk) begin
    if (!areset && (resp0_valid || resp1_valid)) begin
      checks++;
      if (resp0_valid && resp1_valid) begin
        errors++;
        $display("FAIL resp_both: got both response pulses, expected one");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got pulse on resp%0d, expected none", resp1_valid);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        if ((resp1_valid ? 1 : 0) != x.idx ||
            (resp1_valid ? resp1_rdata : resp0_rdata) !== x.rdata ||
            (resp1_valid ? resp1_err : resp0_err) !== x.err) begin
          errors++;
          $display("FAIL resp_match: got idx %0d rdata %h err %b expected idx %0d rdata %h err %b",
                   resp1_valid, resp1_valid ? resp1_rdata : resp0_rdata,
                   resp1_valid ? resp1_err : resp0_err, x.idx, x.rdata, x.err);
        end
      end
    end
  end

  // Drives one command and returns at posedge+1 after the acceptance cycle.
  task automatic issue(input int idx, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    bit got = 0;
    @(posedge aclk); #1;
    if (idx == 0) begin
      req0_write = wr; req0_addr = a; req0_wdata = d; req0_wstrb = s; req0_valid = 1;
    end else begin
      req1_write = wr; req1_addr = a; req1_wdata = d; req1_wstrb = s; req1_valid = 1;
    end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge aclk);
      got = (idx == 0) ? req0_ready : req1_ready;
    end
    if (!got) chk($sformatf("accept_timeout%0d", idx), 0, 1);
    @(posedge aclk); #1;
    if (idx == 0) req0_valid = 0;
    else req1_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge aclk);
    chk("drain", exp_q.size(), 0);
    repeat (2) @(negedge aclk);
  endtask

  logic [31:0] outs_all;
  always_comb outs_all = {awvalid, wvalid, bready, arvalid, rready, req0_ready, req1_ready,
                          resp0_valid, resp1_valid, resp0_err, resp1_err};

  initial begin
    int aw_cnt, w_cnt, early_b;
    bit seen;
    #12;
    chk("reset_ctrl", outs_all, 0);
    chk("reset_payload", {awaddr, wdata}, 0);
    chk("reset_payload2", {araddr, wstrb, awprot, arprot, resp0_rdata}, 0);
    @(posedge aclk); #1 areset = 0;

    // First tie: pointer resets to 1, so req0 wins.
    push_exp(0, 0, 0); push_exp(1, 0, 0);
    fork
      issue(0, 1, 1, 32'h11, 4'hF);
      issue(1, 1, 2, 32'h22, 4'hF);
    join
    drain();

    // Ideal-slave write timing.
    push_exp(0, 0, 0);
    issue(0, 1, 0, 130, 4'hF);
    @(negedge aclk);
    chk("t1_awvalid_wvalid", {awvalid, wvalid, bready}, 3'b110);
    chk("t1_payload", {awaddr, wdata, wstrb}, {32'd0, 32'd130, 4'hF});
    @(negedge aclk);
    chk("t2_bready", {awvalid, wvalid, bready}, 3'b001);
    @(negedge aclk);
    chk("t3_resp0", {resp0_valid, resp0_err}, 2'b10);
    drain();

    // Pointer is now 0 (last grant req0): req1 wins the next tie.
`ifdef AXI_UART_ARB_FIXED_PRIO_EN
    push_exp(0, 0, 0); push_exp(1, 0, 0);
`else
    push_exp(1, 0, 0); push_exp(0, 0, 0);
`endif
    fork
      issue(0, 1, 1, 32'h33, 4'hF);
      issue(1, 1, 2, 32'h44, 4'h3);
    join
    drain();

    // req1 read of RX data.
    r_data_cfg = 32'hF0B4A596;
    push_exp(1, 32'hF0B4A596, 0);
    issue(1, 0, 3, 0, 0);
    @(negedge aclk);
    chk("rd_ar", {arvalid, araddr}, {1'b1, 32'd3});
    drain();

    // awready delayed 5 cycles, wready immediate.
    aw_delay = 5;
    push_exp(0, 0, 0);
    issue(0, 1, 2, 32'h41, 4'h1);
    aw_cnt = 0; w_cnt = 0; early_b = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge aclk);
      aw_cnt += int'(awvalid);
      w_cnt  += int'(wvalid);
      if (bready && (aw_cnt < 6)) early_b++;
    end
    chk("aw_held", aw_cnt, 6);
    chk("w_held", w_cnt, 1);
    chk("bready_early", early_b, 0);
    aw_delay = 0;
    drain();

    // SLVERR surfaces as a single-cycle err.
    b_resp_cfg = 2'b10;
    push_exp(0, 0, 1);
    issue(0, 1, 1, 32'h5, 4'hF);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge aclk);
      seen = resp0_valid;
    end
    chk("slverr_seen", seen, 1);
    @(negedge aclk);
    chk("slverr_one_cycle", resp0_err, 0);
    b_resp_cfg = 2'b00;
    drain();

    // Reset while waiting for bvalid: no response may follow.
    b_hold = 1;
    issue(0, 1, 0, 32'h99, 4'hF);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge aclk);
      seen = bready;
    end
    chk("rst_reached_wresp", seen, 1);
    #2 areset = 1;
    #1 chk("rst_async_outs", outs_all, 0);
    chk("rst_async_payload", {awaddr, wdata}, 0);
    @(posedge aclk); #1 areset = 0; b_hold = 0;
    repeat (6) @(negedge aclk);
    r_data_cfg = 32'h12345678;
    push_exp(1, 32'h12345678, 0);
    issue(1, 0, 3, 0, 0);
    drain();

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
